// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the 14-bit ADC DDR receive path.
// The link code is self-inverse: MSB passes through, the remaining bits are inverted.
package adc_rx_pkg;

    localparam int ADC_DW    = 14;
    localparam int ADC_LANES = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic pair_x;
        logic swap;
    } align_t;

    function automatic logic [ADC_DW-1:0] adc_encode(input logic [ADC_DW-1:0] d);
        return {d[ADC_DW-1], ~d[ADC_DW-2:0]};
    endfunction

    function automatic logic [ADC_DW-1:0] adc_decode(input logic [ADC_DW-1:0] w);
        return {w[ADC_DW-1], ~w[ADC_DW-2:0]};
    endfunction

endpackage

// File: rtl/adc_ddr_rx_if.sv
// Lane samples, control and result bundle between the IDDR front end and the receiver.
interface adc_ddr_rx_if
    import adc_rx_pkg::*;
#(
    parameter int LANES = ADC_LANES
);
    logic [LANES-1:0] adc_ddr_r_i;
    logic [LANES-1:0] adc_ddr_f_i;
    logic             train_start_i;
    logic             chk_en_i;
    logic [15:0]      adc_dat_o;
    logic             adc_vld_o;
    logic [1:0]       align_o;
    logic [1:0]       state_o;
    logic [15:0]      err_cnt_o;

    modport slave (
        input  adc_ddr_r_i, adc_ddr_f_i, train_start_i, chk_en_i,
        output adc_dat_o, adc_vld_o, align_o, state_o, err_cnt_o
    );

    modport master (
        output adc_ddr_r_i, adc_ddr_f_i, train_start_i, chk_en_i,
        input  adc_dat_o, adc_vld_o, align_o, state_o, err_cnt_o
    );
endinterface

// File: rtl/adc_rx_align_fsm.sv
// Training FSM: walks the four lane-pairing candidates until the raw word matches
// the training pattern LOCK_CNT times in a row, then counts mismatches while locked.
module adc_rx_align_fsm
    import adc_rx_pkg::*;
#(
    parameter int            DW        = ADC_DW,
    parameter logic [DW-1:0] TRAIN_PAT = 14'h2A55,
    parameter int            LOCK_CNT  = 16,
    parameter int            TRY_CYC   = 64
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic [DW-1:0] raw_i,
    input  logic          train_start_i,
    input  logic          chk_en_i,
    output align_t        align_o,
    output rx_state_e     state_o,
    output logic          vld_o,
    output logic [15:0]   err_cnt_o
);

    rx_state_e   state_q;
    logic [1:0]  cand_q;
    logic [7:0]  match_q;
    logic [15:0] try_q;
    logic        flush_q;
    logic [15:0] err_q;
    logic        vld_q;

    logic        hit;
    logic [7:0]  match_inc;

    // The first cycle on a new candidate is skipped so f_prev belongs to it.
    assign hit       = !flush_q && (raw_i == TRAIN_PAT);
    assign match_inc = match_q + 8'd1;

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            state_q <= ST_IDLE;
            cand_q  <= 2'd0;
            match_q <= 8'd0;
            try_q   <= 16'd0;
            flush_q <= 1'b0;
            err_q   <= 16'd0;
            vld_q   <= 1'b0;
        end else if (train_start_i) begin
            state_q <= ST_SEARCH;
            cand_q  <= 2'd0;
            match_q <= 8'd0;
            try_q   <= 16'd0;
            flush_q <= 1'b1;
            err_q   <= 16'd0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (hit && (match_inc == 8'(LOCK_CNT))) begin
                        state_q <= ST_LOCKED;
                        vld_q   <= 1'b1;
                        match_q <= match_inc;
                    end else if (try_q == 16'(TRY_CYC - 1)) begin
                        match_q <= 8'd0;
                        try_q   <= 16'd0;
                        flush_q <= 1'b1;
                        if (cand_q == 2'd3) begin
                            state_q <= ST_FAIL;
                            cand_q  <= 2'd0;
                        end else begin
                            cand_q  <= cand_q + 2'd1;
                        end
                    end else begin
                        try_q   <= try_q + 16'd1;
                        match_q <= hit ? match_inc : 8'd0;
                        flush_q <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (chk_en_i && (raw_i != TRAIN_PAT) && (err_q != 16'hFFFF)) begin
                        err_q <= err_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign align_o   = align_t'(cand_q);
    assign state_o   = state_q;
    assign vld_o     = vld_q;
    assign err_cnt_o = err_q;

endmodule

// File: rtl/adc_ddr_rx.sv
// ADC DDR receiver: registers IDDR lane samples, reassembles the word for the
// current pairing candidate, decodes it and sign-extends it to 16 bits.
module adc_ddr_rx
    import adc_rx_pkg::*;
#(
    parameter int            DW        = ADC_DW,
    parameter int            LANES     = ADC_LANES,
    parameter logic [DW-1:0] TRAIN_PAT = 14'h2A55,
    parameter int            LOCK_CNT  = 16,
    parameter int            TRY_CYC   = 64
) (
    input  logic         adc_clk_i,
    input  logic         adc_rst_i,
    adc_ddr_rx_if.slave  bus
);

    logic [LANES-1:0] r_q;
    logic [LANES-1:0] f_q;
    logic [LANES-1:0] fp_q;
    logic [DW-1:0]    d_q;

    logic [LANES-1:0] b_sel;
    logic [DW-1:0]    w;
    align_t           align;
    rx_state_e        state;
    logic             vld;
    logic [15:0]      err_cnt;

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            r_q  <= '0;
            f_q  <= '0;
            fp_q <= '0;
            d_q  <= '0;
        end else begin
            r_q  <= bus.adc_ddr_r_i;
            f_q  <= bus.adc_ddr_f_i;
            fp_q <= f_q;
            d_q  <= adc_decode(w);
        end
    end

    // pair_x pairs each rising sample with the falling sample half a cycle earlier.
    assign b_sel = align.pair_x ? fp_q : f_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w[2*gi+1] = align.swap ? b_sel[gi] : r_q[gi];
        assign w[2*gi]   = align.swap ? r_q[gi]   : b_sel[gi];
    end

    adc_rx_align_fsm #(
        .DW        (DW),
        .TRAIN_PAT (TRAIN_PAT),
        .LOCK_CNT  (LOCK_CNT),
        .TRY_CYC   (TRY_CYC)
    ) u_fsm (
        .adc_clk_i     (adc_clk_i),
        .adc_rst_i     (adc_rst_i),
        .raw_i         (w),
        .train_start_i (bus.train_start_i),
        .chk_en_i      (bus.chk_en_i),
        .align_o       (align),
        .state_o       (state),
        .vld_o         (vld),
        .err_cnt_o     (err_cnt)
    );

    assign bus.adc_dat_o = {{(16-DW){d_q[DW-1]}}, d_q};
    assign bus.adc_vld_o = vld;
    assign bus.align_o   = align;
    assign bus.state_o   = state;
    assign bus.err_cnt_o = err_cnt;

endmodule
